egress_pkt_rx: RTL and testbench

- Downstream consumer attached to one switch output port (A, B, C or D). Drives that port's X_ready.
- Validates each packet's framing and destination header, then buffers it store-and-forward.
- Releases only complete, good packets to the egress link via a valid/ready interface.
- Drops and counts malformed, misrouted and oversize packets.

---
 rtl/switch_pkg.sv | 42 ++++
 rtl/pkt_buf_mem.sv | 29 ++
 rtl/egress_pkt_rx.sv | 192 +++++++++++++++++++
 tb/tb_egress_pkt_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared definitions for the switch egress path: port ids, header field
// position, buffer word layout and small helpers used by the receivers.
package switch_pkg;

  localparam int WORD_W     = 32;
  localparam int HDR_ID_MSB = 31;
  localparam int HDR_ID_LSB = 24;

  localparam logic [7:0] PORT_A = 8'd0;
  localparam logic [7:0] PORT_B = 8'd1;
  localparam logic [7:0] PORT_C = 8'd2;
  localparam logic [7:0] PORT_D = 8'd3;

  // One buffered word: framing flags travel with the data
  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [WORD_W-1:0] data;
  } pkt_word_t;

  // Receive-side framing state
  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_RECV    = 2'd1,
    RX_DISCARD = 2'd2
  } rx_state_t;

  // Port D is the catch-all: it also accepts every id above PORT_C
  function automatic logic hdr_match(input logic [7:0] id, input int port_id);
    return (int'(id) == port_id) ||
           ((port_id == int'(PORT_D)) && (id > PORT_C));
  endfunction

  // Saturating 16-bit counter step (increment of 0..3)
  function automatic logic [15:0] sat_add16(input logic [15:0] cnt,
                                            input logic [1:0]  inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/pkt_buf_mem.sv
// Packet buffer storage: DEPTH x pkt_word_t registers, one synchronous
// write port and one combinational read port for fall-through output.
module pkt_buf_mem
  import switch_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pkt_word_t         wr_word,
  input  logic [ADDR_W-1:0] rd_addr,
  output pkt_word_t         rd_word
);

  pkt_word_t mem [DEPTH];

  // Storage write; contents need no reset because only committed
  // entries are ever presented downstream
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  assign rd_word = mem[rd_addr];

endmodule

// File: rtl/egress_pkt_rx.sv
// Egress receiver for one switch output port. Checks framing and the
// destination header, buffers packets store-and-forward with a speculative
// write pointer, and only exposes packets once their eop has been written.
module egress_pkt_rx
  import switch_pkg::*;
#(
  parameter int PORT_ID = 0,
  parameter int DEPTH   = 16,
  parameter int MAX_PKT = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  input  logic              out_ready,
  output logic [15:0]       pkt_count,
  output logic [15:0]       drop_count,
  output logic [15:0]       misroute_count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int FREE_W = ADDR_W + 2;

  rx_state_t state, state_nx;

  logic [PTR_W-1:0] wr_ptr, wr_ptr_nx;
  logic [PTR_W-1:0] start_ptr, start_nx;
  logic [PTR_W-1:0] commit_ptr, commit_nx;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] hdr_base;
  logic [PTR_W-1:0] used;
  logic [PTR_W-1:0] pkt_len;
  logic [FREE_W-1:0] free;

  logic             run;
  logic             wr_en;
  logic [ADDR_W-1:0] wr_addr;
  pkt_word_t        wr_word;
  pkt_word_t        rd_word;
  logic             do_hdr;
  logic             pkt_inc;
  logic             mis_inc;
  logic [1:0]       drop_inc;
  logic             out_xfer;

  assign used    = wr_ptr - rd_ptr;
  assign free    = FREE_W'(DEPTH) - FREE_W'(used);
  assign pkt_len = wr_ptr - start_ptr;

  pkt_buf_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_word (wr_word),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_word (rd_word)
  );

  // Output side: only words between rd_ptr and commit_ptr are visible,
  // and the data lines are held at zero whenever nothing is offered
  always_comb begin
    out_valid = (rd_ptr != commit_ptr);
    out_data  = out_valid ? rd_word.data : '0;
    out_sop   = out_valid & rd_word.sop;
    out_eop   = out_valid & rd_word.eop;
    out_xfer  = out_valid & out_ready;
  end

  // Framing FSM: decides what to write, where, and when to commit or roll
  // back. A header arriving mid-packet is folded into the header path with
  // its write base moved back to the aborted packet's start.
  always_comb begin
    state_nx = state;
    wr_ptr_nx = wr_ptr;
    start_nx = start_ptr;
    commit_nx = commit_ptr;
    wr_en = 1'b0;
    wr_addr = wr_ptr[ADDR_W-1:0];
    wr_word = '{sop: in_sop, eop: in_eop, data: in_data};
    pkt_inc = 1'b0;
    mis_inc = 1'b0;
    drop_inc = 2'd0;
    do_hdr = 1'b0;
    hdr_base = wr_ptr;
    in_ready = 1'b0;

    case (state)
      RX_IDLE: begin
        in_ready = run && (free >= FREE_W'(MAX_PKT));
        if (in_valid && in_ready) begin
          if (in_sop) begin
            do_hdr = 1'b1;
          end else begin
            drop_inc = 2'd1;
          end
        end
      end
      RX_RECV: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_sop) begin
            drop_inc = 2'd1;
            hdr_base = start_ptr;
            do_hdr = 1'b1;
          end else if (pkt_len >= PTR_W'(MAX_PKT)) begin
            wr_ptr_nx = start_ptr;
            drop_inc = 2'd1;
            state_nx = in_eop ? RX_IDLE : RX_DISCARD;
          end else begin
            wr_en = 1'b1;
            wr_ptr_nx = wr_ptr + 1'b1;
            if (in_eop) begin
              commit_nx = wr_ptr + 1'b1;
              pkt_inc = 1'b1;
              state_nx = RX_IDLE;
            end
          end
        end
      end
      RX_DISCARD: begin
        in_ready = 1'b1;
        if (in_valid && in_eop) begin
          state_nx = RX_IDLE;
        end
      end
      default: begin
        state_nx = RX_IDLE;
      end
    endcase

    if (do_hdr) begin
      wr_ptr_nx = hdr_base;
      if (hdr_match(in_data[HDR_ID_MSB:HDR_ID_LSB], PORT_ID)) begin
        wr_en = 1'b1;
        wr_addr = hdr_base[ADDR_W-1:0];
        wr_ptr_nx = hdr_base + 1'b1;
        start_nx = hdr_base;
        if (in_eop) begin
          commit_nx = hdr_base + 1'b1;
          pkt_inc = 1'b1;
          state_nx = RX_IDLE;
        end else begin
          state_nx = RX_RECV;
        end
      end else begin
        mis_inc = 1'b1;
        drop_inc = drop_inc + 2'd1;
        state_nx = in_eop ? RX_IDLE : RX_DISCARD;
      end
    end
  end

  // State, pointers and statistics; run keeps in_ready low until the
  // first clock after reset release
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= RX_IDLE;
      run <= 1'b0;
      wr_ptr <= '0;
      start_ptr <= '0;
      commit_ptr <= '0;
      rd_ptr <= '0;
      pkt_count <= '0;
      drop_count <= '0;
      misroute_count <= '0;
    end else begin
      state <= state_nx;
      run <= 1'b1;
      wr_ptr <= wr_ptr_nx;
      start_ptr <= start_nx;
      commit_ptr <= commit_nx;
      if (out_xfer) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      pkt_count <= sat_add16(pkt_count, {1'b0, pkt_inc});
      drop_count <= sat_add16(drop_count, drop_inc);
      misroute_count <= sat_add16(misroute_count, {1'b0, mis_inc});
    end
  end

endmodule

// File: tb/tb_egress_pkt_rx.sv
// Directed bench for egress_pkt_rx: one instance serving port A and one
// serving port D, sharing the input word lines with separate valids.
module tb_egress_pkt_rx;
  import switch_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] in_data;
  logic        in_valid, in_sop, in_eop, sel, out_ready;
  logic        in_valid0, in_valid3;

  logic        in_ready0, out_valid0, out_sop0, out_eop0;
  logic [31:0] out_data0;
  logic [15:0] pkt_count0, drop_count0, misroute_count0;

  logic        in_ready3, out_valid3, out_sop3, out_eop3;
  logic [31:0] out_data3;
  logic [15:0] pkt_count3, drop_count3, misroute_count3;

  int compared = 0;
  int mismatched = 0;
  int cycle = 0;
  int eop_cycle = 0;

  typedef struct {
    int          cyc;
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } mon_t;

  mon_t q0[$];
  mon_t q3[$];

  assign in_valid0 = in_valid & ~sel;
  assign in_valid3 = in_valid & sel;

  egress_pkt_rx #(.PORT_ID(0), .DEPTH(16), .MAX_PKT(8)) dut0 (
    .clk(clk), .nrst(nrst),
    .in_data(in_data), .in_valid(in_valid0), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_sop(out_sop0),
    .out_eop(out_eop0), .out_ready(out_ready),
    .pkt_count(pkt_count0), .drop_count(drop_count0),
    .misroute_count(misroute_count0)
  );

  egress_pkt_rx #(.PORT_ID(3), .DEPTH(16), .MAX_PKT(8)) dut3 (
    .clk(clk), .nrst(nrst),
    .in_data(in_data), .in_valid(in_valid3), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_sop(out_sop3),
    .out_eop(out_eop3), .out_ready(out_ready),
    .pkt_count(pkt_count3), .drop_count(drop_count3),
    .misroute_count(misroute_count3)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle index used to time when output words first appear
  always @(posedge clk) cycle <= cycle + 1;

  // Record every output transfer, sampled mid-cycle
  always @(negedge clk) begin
    if (out_valid0 && out_ready) q0.push_back('{cycle, out_sop0, out_eop0, out_data0});
    if (out_valid3 && out_ready) q3.push_back('{cycle, out_sop3, out_eop3, out_data3});
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one word to the selected instance and hold it until accepted
  task automatic applyStimulus(input logic inst, input logic [31:0] data,
                               input logic sop, input logic eop);
    int waits;
    waits = 0;
    sel = inst;
    in_data = data;
    in_sop = sop;
    in_eop = eop;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (inst ? in_ready3 : in_ready0) break;
      waits++;
      if (waits > 100) begin
        compared++;
        mismatched++;
        $error("[TB] FAIL in_ready_timeout: observed 0 expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    if (eop) eop_cycle = cycle;
  endtask

  // Header followed by n payload words pbase+1..pbase+n; eop on the last
  // word only when with_eop is set
  task automatic sendPkt(input logic inst, input logic [31:0] hdr, input int n,
                         input logic [31:0] pbase, input logic with_eop);
    applyStimulus(inst, hdr, 1'b1, (n == 0) && with_eop);
    for (int i = 1; i <= n; i++) begin
      applyStimulus(inst, pbase + 32'(i), 1'b0, (i == n) && with_eop);
    end
  endtask

  task automatic checkWord(input logic inst, input int idx, input logic [31:0] d,
                           input logic s, input logic e, input string tag);
    mon_t m;
    logic [63:0] obs;
    obs = 64'hDEAD_0000_0000_0000;
    if (!inst && idx < q0.size()) begin
      m = q0[idx];
      obs = {30'd0, m.sop, m.eop, m.data};
    end else if (inst && idx < q3.size()) begin
      m = q3[idx];
      obs = {30'd0, m.sop, m.eop, m.data};
    end
    checkOutput(tag, obs, {30'd0, s, e, d});
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Directed test sequence
  initial begin
    in_data = '0;
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    sel = 1'b0;
    out_ready = 1'b1;
    nrst = 1'b0;
    waitCycles(3);

    checkOutput("rst_in_ready", 64'(in_ready0), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid0), 64'd0);
    checkOutput("rst_out_data", 64'(out_data0), 64'd0);
    checkOutput("rst_pkt_count", 64'(pkt_count0), 64'd0);
    checkOutput("rst_drop_count", 64'(drop_count0), 64'd0);

    nrst = 1'b1;
    waitCycles(2);
    checkOutput("idle_in_ready", 64'(in_ready0), 64'd1);

    // Six-word packet, fall-through starting right after the eop edge
    sendPkt(1'b0, 32'h0000_0100, 5, 32'h0, 1'b1);
    waitCycles(10);
    checkOutput("t1_words", 64'(q0.size()), 64'd6);
    checkWord(1'b0, 0, 32'h0000_0100, 1'b1, 1'b0, "t1_w0");
    for (int i = 1; i <= 5; i++) begin
      checkWord(1'b0, i, 32'(i), 1'b0, (i == 5), $sformatf("t1_w%0d", i));
    end
    checkOutput("t1_first_cycle", 64'(q0.size() > 0 ? q0[0].cyc : -1), 64'(eop_cycle));
    checkOutput("t1_pkt_count", 64'(pkt_count0), 64'd1);
    q0.delete();

    // Single-word packet
    sendPkt(1'b0, 32'h0012_3456, 0, 32'h0, 1'b1);
    waitCycles(6);
    checkOutput("t2_words", 64'(q0.size()), 64'd1);
    checkWord(1'b0, 0, 32'h0012_3456, 1'b1, 1'b1, "t2_w0");
    checkOutput("t2_pkt_count", 64'(pkt_count0), 64'd2);
    checkOutput("t2_drop_count", 64'(drop_count0), 64'd0);
    q0.delete();

    // Port D: id 9 forwarded, id 1 misrouted
    sendPkt(1'b1, 32'h0900_0000, 3, 32'h0000_0900, 1'b1);
    sendPkt(1'b1, 32'h0100_0000, 3, 32'h0000_0100, 1'b1);
    waitCycles(8);
    checkOutput("t3_words", 64'(q3.size()), 64'd4);
    checkWord(1'b1, 0, 32'h0900_0000, 1'b1, 1'b0, "t3_w0");
    for (int i = 1; i <= 3; i++) begin
      checkWord(1'b1, i, 32'h0000_0900 + 32'(i), 1'b0, (i == 3), $sformatf("t3_w%0d", i));
    end
    checkOutput("t3_misroute", 64'(misroute_count3), 64'd1);
    checkOutput("t3_drop", 64'(drop_count3), 64'd1);
    checkOutput("t3_pkt_count", 64'(pkt_count3), 64'd1);

    // Framing error: second header aborts the first packet
    sendPkt(1'b0, 32'h00F0_0000, 2, 32'h0, 1'b0);
    sendPkt(1'b0, 32'h00F0_0001, 1, 32'h6, 1'b1);
    waitCycles(6);
    checkOutput("t4_words", 64'(q0.size()), 64'd2);
    checkWord(1'b0, 0, 32'h00F0_0001, 1'b1, 1'b0, "t4_w0");
    checkWord(1'b0, 1, 32'h0000_0007, 1'b0, 1'b1, "t4_w1");
    checkOutput("t4_drop", 64'(drop_count0), 64'd1);
    checkOutput("t4_pkt_count", 64'(pkt_count0), 64'd3);
    q0.delete();

    // Oversize: header plus nine payload words
    sendPkt(1'b0, 32'h00C0_0000, 9, 32'h00C0_0000, 1'b1);
    waitCycles(6);
    checkOutput("t5_words", 64'(q0.size()), 64'd0);
    checkOutput("t5_drop", 64'(drop_count0), 64'd2);
    checkOutput("t5_pkt_count", 64'(pkt_count0), 64'd3);
    checkOutput("t5_in_ready", 64'(in_ready0), 64'd1);

    // Backpressure: two full-size packets fill the buffer
    out_ready = 1'b0;
    sendPkt(1'b0, 32'h00A0_0000, 7, 32'h00A0_0000, 1'b1);
    sendPkt(1'b0, 32'h00B0_0000, 7, 32'h00B0_0000, 1'b1);
    waitCycles(3);
    checkOutput("t5b_full_ready", 64'(in_ready0), 64'd0);
    checkOutput("t5b_full_valid", 64'(out_valid0), 64'd1);
    out_ready = 1'b1;
    waitCycles(4);
    checkOutput("t5b_half_ready", 64'(in_ready0), 64'd0);
    waitCycles(4);
    checkOutput("t5b_free_ready", 64'(in_ready0), 64'd1);
    waitCycles(10);
    checkOutput("t5b_words", 64'(q0.size()), 64'd16);
    for (int i = 0; i < 8; i++) begin
      checkWord(1'b0, i, 32'h00A0_0000 + 32'(i), (i == 0), (i == 7), $sformatf("t5b_a%0d", i));
      checkWord(1'b0, i + 8, 32'h00B0_0000 + 32'(i), (i == 0), (i == 7), $sformatf("t5b_b%0d", i));
    end
    checkOutput("t5b_pkt_count", 64'(pkt_count0), 64'd5);
    q0.delete();

    // Reset in the middle of a packet
    sendPkt(1'b0, 32'h0000_0300, 2, 32'h0000_0300, 1'b0);
    nrst = 1'b0;
    #1;
    checkOutput("t6_in_ready", 64'(in_ready0), 64'd0);
    checkOutput("t6_out_valid", 64'(out_valid0), 64'd0);
    checkOutput("t6_out_data", 64'(out_data0), 64'd0);
    checkOutput("t6_pkt_count", 64'(pkt_count0), 64'd0);
    checkOutput("t6_drop_count", 64'(drop_count0), 64'd0);
    checkOutput("t6_misroute3", 64'(misroute_count3), 64'd0);
    waitCycles(2);
    nrst = 1'b1;
    waitCycles(2);
    q0.delete();
    sendPkt(1'b0, 32'h0000_0400, 1, 32'h0000_0400, 1'b1);
    waitCycles(6);
    checkOutput("t6_words", 64'(q0.size()), 64'd2);
    checkWord(1'b0, 0, 32'h0000_0400, 1'b1, 1'b0, "t6_w0");
    checkWord(1'b0, 1, 32'h0000_0401, 1'b0, 1'b1, "t6_w1");
    checkOutput("t6_pkt_after", 64'(pkt_count0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
